// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the two-master memory bus arbiter.
package mem_bus_arbiter_pkg;

    localparam int WAIT_CNT_W = 4;
    localparam int DATA_W     = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } mem_arb_state_e;

    typedef enum logic {
        ARB_M0 = 1'b0,
        ARB_M1 = 1'b1
    } mem_arb_owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between the CPU (master 0) and the DMA/loader (master 1).
// MEM_ARB_RR_EN selects round-robin tie-break; otherwise the CPU always wins ties.
module mem_arb_pick
    import mem_bus_arbiter_pkg::*;
(
    input  logic m0_req,
    input  logic m1_req,
    input  logic last_owner,
    output logic grant_valid,
    output logic grant
);

`ifndef MEM_ARB_RR_EN
    logic unused_last_owner;
    assign unused_last_owner = last_owner;
`endif

    always_comb begin
        grant_valid = m0_req | m1_req;
        grant       = ARB_M0;
        if (m0_req && m1_req) begin
`ifdef MEM_ARB_RR_EN
            // Tie goes to whichever master did not win the previous grant.
            grant = (last_owner == ARB_M0) ? ARB_M1 : ARB_M0;
`else
            grant = ARB_M0;
`endif
        end else if (m1_req) begin
            grant = ARB_M1;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the single 16-bit memory port: grant, hold strobes for
// WAIT_CYCLES, then one-cycle ack. Build with MEM_ARB_RR_EN for round-robin ties.
//
// state  | meaning
// IDLE   | no transaction; requests sampled, winner latched on grant
// ACCESS | memory strobe held while wait counter runs down to zero
// RESP   | owner's ack pulses for this one cycle, strobes low
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int WAIT_CYCLES = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_m0_req,
    input  logic        i_m0_we,
    input  logic [15:0] i_m0_addr,
    input  logic [15:0] i_m0_wdata,
    output logic        o_m0_ack,
    input  logic        i_m1_req,
    input  logic        i_m1_we,
    input  logic [15:0] i_m1_addr,
    input  logic [15:0] i_m1_wdata,
    output logic        o_m1_ack,
    output logic [15:0] o_rdata,
    output logic [15:0] o_mem_addr,
    output logic [15:0] o_mem_wdata,
    output logic        o_mem_rd,
    output logic        o_mem_wr,
    input  logic [15:0] i_mem_rdata,
    output logic        o_busy,
    output logic        o_owner
);

    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("mem_bus_arbiter: WAIT_CYCLES must be 1..15");
    end

    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_CYCLES - 1);

    mem_arb_state_e        state_q, state_d;
    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
    logic                  load;
    logic                  capture;

    logic                  we_q;
    logic [DATA_W-1:0]     addr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [DATA_W-1:0]     rdata_q;
    mem_arb_owner_e        owner_q;

    logic                  grant_valid;
    logic                  grant_raw;
    mem_arb_owner_e        grant_owner;
    logic                  last_owner;

    logic                  win_we;
    logic [DATA_W-1:0]     win_addr;
    logic [DATA_W-1:0]     win_wdata;

    mem_arb_pick u_pick (
        .m0_req      (i_m0_req),
        .m1_req      (i_m1_req),
        .last_owner  (last_owner),
        .grant_valid (grant_valid),
        .grant       (grant_raw)
    );

    assign grant_owner = mem_arb_owner_e'(grant_raw);

`ifdef MEM_ARB_RR_EN
    mem_arb_owner_e last_owner_q;

    // Reset to M1 so the first tie after reset goes to the CPU.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            last_owner_q <= ARB_M1;
        end else if (load) begin
            last_owner_q <= grant_owner;
        end
    end

    assign last_owner = last_owner_q;
`else
    assign last_owner = ARB_M0;
`endif

    always_comb begin
        win_we    = i_m0_we;
        win_addr  = i_m0_addr;
        win_wdata = i_m0_wdata;
        if (grant_owner == ARB_M1) begin
            win_we    = i_m1_we;
            win_addr  = i_m1_addr;
            win_wdata = i_m1_wdata;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    load    = 1'b1;
                    cnt_d   = WAIT_LOAD;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    capture = !we_q;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            owner_q <= ARB_M0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (load) begin
                we_q    <= win_we;
                addr_q  <= win_addr;
                wdata_q <= win_wdata;
                owner_q <= grant_owner;
            end
            if (capture) begin
                rdata_q <= i_mem_rdata;
            end
        end
    end

    assign o_busy      = (state_q != IDLE);
    assign o_owner     = owner_q;
    assign o_mem_addr  = addr_q;
    assign o_mem_wdata = wdata_q;
    assign o_mem_rd    = (state_q == ACCESS) && !we_q;
    assign o_mem_wr    = (state_q == ACCESS) && we_q;
    assign o_m0_ack    = (state_q == RESP) && (owner_q == ARB_M0);
    assign o_m1_ack    = (state_q == RESP) && (owner_q == ARB_M1);
    assign o_rdata     = rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: two instances (WAIT_CYCLES 1 and 3) share stimulus;
// one is selected at a time and compared every cycle against a transaction-timeline model.
module tb_mem_bus_arbiter;

`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
    logic [15:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0, mem_rdata = 0;

    logic        ack0_a, ack1_a, rd_a, wr_a, busy_a, own_a;
    logic [15:0] rdata_a, maddr_a, mwdata_a;
    logic        ack0_b, ack1_b, rd_b, wr_b, busy_b, own_b;
    logic [15:0] rdata_b, maddr_b, mwdata_b;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.WAIT_CYCLES(1)) u_dut_a (
        .i_clk(clk), .i_rst(rst),
        .i_m0_req(m0_req), .i_m0_we(m0_we), .i_m0_addr(m0_addr), .i_m0_wdata(m0_wdata), .o_m0_ack(ack0_a),
        .i_m1_req(m1_req), .i_m1_we(m1_we), .i_m1_addr(m1_addr), .i_m1_wdata(m1_wdata), .o_m1_ack(ack1_a),
        .o_rdata(rdata_a), .o_mem_addr(maddr_a), .o_mem_wdata(mwdata_a), .o_mem_rd(rd_a), .o_mem_wr(wr_a),
        .i_mem_rdata(mem_rdata), .o_busy(busy_a), .o_owner(own_a)
    );

    mem_bus_arbiter #(.WAIT_CYCLES(3)) u_dut_b (
        .i_clk(clk), .i_rst(rst),
        .i_m0_req(m0_req), .i_m0_we(m0_we), .i_m0_addr(m0_addr), .i_m0_wdata(m0_wdata), .o_m0_ack(ack0_b),
        .i_m1_req(m1_req), .i_m1_we(m1_we), .i_m1_addr(m1_addr), .i_m1_wdata(m1_wdata), .o_m1_ack(ack1_b),
        .o_rdata(rdata_b), .o_mem_addr(maddr_b), .o_mem_wdata(mwdata_b), .o_mem_rd(rd_b), .o_mem_wr(wr_b),
        .i_mem_rdata(mem_rdata), .o_busy(busy_b), .o_owner(own_b)
    );

    int sel_w = 1;
    logic        s_ack0, s_ack1, s_rd, s_wr, s_busy, s_own;
    logic [15:0] s_rdata, s_maddr, s_mwdata;
    assign s_ack0   = (sel_w == 1) ? ack0_a   : ack0_b;
    assign s_ack1   = (sel_w == 1) ? ack1_a   : ack1_b;
    assign s_rd     = (sel_w == 1) ? rd_a     : rd_b;
    assign s_wr     = (sel_w == 1) ? wr_a     : wr_b;
    assign s_busy   = (sel_w == 1) ? busy_a   : busy_b;
    assign s_own    = (sel_w == 1) ? own_a    : own_b;
    assign s_rdata  = (sel_w == 1) ? rdata_a  : rdata_b;
    assign s_maddr  = (sel_w == 1) ? maddr_a  : maddr_b;
    assign s_mwdata = (sel_w == 1) ? mwdata_a : mwdata_b;

    int n_vec = 0;
    int n_err = 0;

    // Model: m_t is the cycle index within the current transaction
    // (0 = idle, 1..W = memory strobe, W+1 = ack).
    int          m_t = 0;
    logic        m_we = 0, m_owner = 0, m_last = 1;
    logic [15:0] m_addr = 0, m_wdata = 0, m_rdata = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic win;
        if (rst) begin
            m_t = 0; m_we = 0; m_owner = 0; m_last = 1;
            m_addr = 0; m_wdata = 0; m_rdata = 0;
        end else if (m_t == 0) begin
            if (m0_req || m1_req) begin
                if (m0_req && m1_req) win = RR ? !m_last : 1'b0;
                else                  win = m1_req;
                m_last  = win;
                m_owner = win;
                m_we    = win ? m1_we    : m0_we;
                m_addr  = win ? m1_addr  : m0_addr;
                m_wdata = win ? m1_wdata : m0_wdata;
                m_t     = 1;
            end
        end else if (m_t <= sel_w) begin
            if (m_t == sel_w && !m_we) m_rdata = mem_rdata;
            m_t++;
        end else begin
            m_t = 0;
        end
    endtask

    task automatic check_all();
        logic strobe, ack;
        strobe = (m_t >= 1) && (m_t <= sel_w);
        ack    = (m_t == sel_w + 1);
        chk("busy",   {15'd0, s_busy}, {15'd0, m_t != 0});
        chk("mem_rd", {15'd0, s_rd},   {15'd0, strobe && !m_we});
        chk("mem_wr", {15'd0, s_wr},   {15'd0, strobe && m_we});
        chk("m0_ack", {15'd0, s_ack0}, {15'd0, ack && !m_owner});
        chk("m1_ack", {15'd0, s_ack1}, {15'd0, ack && m_owner});
        chk("owner",  {15'd0, s_own},  {15'd0, m_owner});
        chk("rdata",  s_rdata,  m_rdata);
        chk("maddr",  s_maddr,  m_addr);
        chk("mwdata", s_mwdata, m_wdata);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic do_reset(input int w);
        sel_w = w;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Ticks until the given master's ack is seen; returns in the ack cycle.
    task automatic wait_ack(input int mst, input int budget);
        logic got;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            tick();
            got = (mst == 0) ? s_ack0 : s_ack1;
        end
        n_vec++;
        assert (got === 1'b1)
        else begin
            n_err++;
            $error("FAIL ack_timeout_m%0d observed=%b expected=1", mst, got);
        end
    endtask

    initial begin
        logic [15:0] seen [4];
        logic [15:0] exp_own [4];

        // 1: m0 read, WAIT_CYCLES=1
        do_reset(1);
        chk("rst_busy", {15'd0, s_busy}, 16'd0);
        chk("rst_rdata", s_rdata, 16'h0000);
        m0_req = 1; m0_we = 0; m0_addr = 16'h0010; mem_rdata = 16'hBEEF;
        tick();
        chk("t1_rd_c1", {15'd0, s_rd}, 16'd1);
        chk("t1_addr_c1", s_maddr, 16'h0010);
        tick();
        chk("t1_ack_c2", {15'd0, s_ack0}, 16'd1);
        chk("t1_rdata", s_rdata, 16'hBEEF);
        m0_req = 0;
        tick();

        // 2: m1 write, WAIT_CYCLES=3, o_rdata must survive it
        do_reset(3);
        m0_req = 1; m0_we = 0; m0_addr = 16'h0020; mem_rdata = 16'h5A5A;
        wait_ack(0, 8);
        m0_req = 0;
        tick();
        m1_req = 1; m1_we = 1; m1_addr = 16'h8000; m1_wdata = 16'h1234; mem_rdata = 16'hFFFF;
        for (int c = 1; c <= 3; c++) begin
            tick();
            chk("t2_wr", {15'd0, s_wr}, 16'd1);
            chk("t2_addr", s_maddr, 16'h8000);
            chk("t2_wdata", s_mwdata, 16'h1234);
        end
        tick();
        chk("t2_ack1", {15'd0, s_ack1}, 16'd1);
        chk("t2_wr_off", {15'd0, s_wr}, 16'd0);
        chk("t2_rdata_kept", s_rdata, 16'h5A5A);
        m1_req = 0;
        tick();

        // 3: both masters request every IDLE cycle
        do_reset(1);
        m0_req = 1; m0_we = 0; m0_addr = 16'h0100;
        m1_req = 1; m1_we = 0; m1_addr = 16'h0200;
        for (int k = 0; k < 4; k++) begin
            exp_own[k] = (RR && (k % 2 == 1)) ? 16'd1 : 16'd0;
            seen[k] = 16'hDEAD;
            for (int c = 0; c < 6 && seen[k] == 16'hDEAD; c++) begin
                tick();
                if (s_ack0 || s_ack1) seen[k] = {15'd0, s_own};
            end
            chk("t3_grant", seen[k], exp_own[k]);
        end
        m0_req = 0; m1_req = 0;
        tick();
        tick();

        // 4: m1 arrives while m0 is in ACCESS
        do_reset(3);
        m0_req = 1; m0_we = 0; m0_addr = 16'h0300; mem_rdata = 16'hA5A5;
        tick();
        m1_req = 1; m1_we = 1; m1_addr = 16'h0400; m1_wdata = 16'h0F0F;
        tick();
        chk("t4_own_m0", {15'd0, s_own}, 16'd0);
        tick();
        chk("t4_own_m0b", {15'd0, s_own}, 16'd0);
        tick();
        chk("t4_ack0", {15'd0, s_ack0}, 16'd1);
        m0_req = 0;
        tick();
        chk("t4_idle", {15'd0, s_busy}, 16'd0);
        tick();
        chk("t4_own_m1", {15'd0, s_own}, 16'd1);
        chk("t4_wr_m1", {15'd0, s_wr}, 16'd1);
        wait_ack(1, 6);
        m1_req = 0;
        tick();

        // 5: reset during a read's ACCESS
        m0_req = 1; m0_we = 0; m0_addr = 16'h0500; mem_rdata = 16'hC0DE;
        tick();
        chk("t5_rd", {15'd0, s_rd}, 16'd1);
        rst = 1;
        tick();
        chk("t5_rd_off", {15'd0, s_rd}, 16'd0);
        chk("t5_ack_off", {15'd0, s_ack0}, 16'd0);
        chk("t5_rdata0", s_rdata, 16'h0000);
        rst = 0;
        wait_ack(0, 8);
        chk("t5_rdata", s_rdata, 16'hC0DE);
        m0_req = 0;
        tick();

        // 6: req held one cycle past ack is a second access
        do_reset(1);
        m0_req = 1; m0_we = 0; m0_addr = 16'h0600; mem_rdata = 16'h1111;
        wait_ack(0, 5);
        mem_rdata = 16'h2222;
        wait_ack(0, 5);
        chk("t6_rdata2", s_rdata, 16'h2222);
        m0_req = 0;
        tick();

        // 7: req dropped mid-access still completes
        m1_req = 1; m1_we = 0; m1_addr = 16'h0700; mem_rdata = 16'h7777;
        tick();
        m1_req = 0;
        wait_ack(1, 4);
        chk("t7_rdata", s_rdata, 16'h7777);
        tick();

        // Random traffic against the model, both wait settings
        for (int d = 0; d < 2; d++) begin
            do_reset(d == 0 ? 3 : 1);
            m0_req = 0; m1_req = 0;
            for (int c = 0; c < 400; c++) begin
                rst = ($urandom_range(79) == 0);
                if (s_ack0)
                    m0_req = ($urandom_range(3) == 0);
                else if (!m0_req && $urandom_range(2) == 0) begin
                    m0_req = 1; m0_we = $urandom_range(1);
                    m0_addr = 16'($urandom); m0_wdata = 16'($urandom);
                end
                if (s_ack1)
                    m1_req = ($urandom_range(3) == 0);
                else if (!m1_req && $urandom_range(2) == 0) begin
                    m1_req = 1; m1_we = $urandom_range(1);
                    m1_addr = 16'($urandom); m1_wdata = 16'($urandom);
                end
                mem_rdata = 16'($urandom);
                tick();
            end
            rst = 0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the single 16-bit memory port between the CPU core (master 0, driven from the instruction decoder's memory read/write strobes and address register) and a second bus master (master 1, DMA/loader). It arbitrates requests, latches the winning transaction, drives the memory strobes for a configurable number of wait cycles, and returns read data with a one-cycle acknowledge. The block sits between the core's bus interface and the memory, replacing the core's direct memory connection.

## Interface
- WAIT_CYCLES, 1, number of cycles the memory strobe is held per access; legal range 1..15
- i_clk  in  1  clock, all state updates on rising edge
- i_rst  in  1  reset. One clock; reset is synchronous and active-high.
- i_m0_req  in  1  master 0 access request, held until ack
- i_m0_we  in  1  master 0 write (1) / read (0)
- i_m0_addr  in  16  master 0 word address
- i_m0_wdata  in  16  master 0 write data
- o_m0_ack  out  1  master 0 access complete, one-cycle pulse
- i_m1_req, i_m1_we, i_m1_addr, i_m1_wdata, o_m1_ack: same as master 0, for master 1
- o_rdata  out  16  read data of last completed read, shared by both masters
- o_mem_addr  out  16  memory address
- o_mem_wdata  out  16  memory write data
- o_mem_rd  out  1  memory read strobe
- o_mem_wr  out  1  memory write strobe
- i_mem_rdata  in  16  memory read data
- o_busy  out  1  transaction in progress (state != IDLE)
- o_owner  out  1  master currently owning the bus (valid when o_busy)

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if any req high, pick winner, latch addr/wdata/we/owner, load wait counter with WAIT_CYCLES-1, go ACCESS. No req: stay.
- ACCESS: o_mem_rd = !we, o_mem_wr = we, address/data from latches. Counter decrements each cycle; when counter == 0, capture i_mem_rdata into o_rdata (reads only), go RESP.
- RESP: ack of owner high for exactly this cycle; strobes low; go IDLE.
- Requests sampled only in IDLE; requester must keep req/we/addr/wdata stable from req rise to ack and drop req at the edge ending the ack cycle. req still high in the following IDLE cycle is a new request.
- Writes leave o_rdata unchanged.
- Arbitration with both requests in the same IDLE cycle: see Configuration. Single request always wins.
- Counter width 4 bits; no wrap, stops at 0.

## Timing
- Reset values: state IDLE, o_m0_ack 0, o_m1_ack 0, o_rdata 0, o_mem_addr 0, o_mem_wdata 0, o_mem_rd 0, o_mem_wr 0, o_busy 0, o_owner 0, round-robin pointer favours master 0.
- Req seen in IDLE at cycle 0 -> ACCESS cycles 1..WAIT_CYCLES -> ack in cycle WAIT_CYCLES+1. WAIT_CYCLES=1: ack in cycle 2; back-to-back throughput one access per WAIT_CYCLES+2 cycles.
- o_rdata valid from the ack cycle, held until next read completes.
- Reset asserted mid-transaction: next edge returns all outputs to reset values; aborted access produces no ack; strobes low in the cycle after reset edge.
- Req dropped mid-transaction (protocol violation): transaction still completes and acks.

## Configuration
- MEM_ARB_RR_EN defined: round-robin. On simultaneous requests the master not granted last wins; pointer updates on every grant.
- MEM_ARB_RR_EN undefined: fixed priority, master 0 (CPU) always wins ties; no pointer register.

## Structure
- Shared package: mem_arb_state_e (IDLE, ACCESS, RESP), mem_arb_owner_e (ARB_M0, ARB_M1), WAIT counter width constant.
- One sub-module: mem_arb_pick, combinational winner selection from two reqs and the last-owner pointer, with the MEM_ARB_RR_EN variant inside it.

## Test plan
- Reset then m0 read addr 0x0010, memory returns 0xBEEF, WAIT_CYCLES=1 -> o_mem_rd high cycle 1 with addr 0x0010, o_m0_ack pulse cycle 2, o_rdata 0xBEEF.
- m1 write addr 0x8000 data 0x1234, WAIT_CYCLES=3 -> o_mem_wr high exactly cycles 1..3 with addr/data, o_m1_ack cycle 4, o_rdata unchanged.
- Both req every IDLE for 4 accesses -> with MEM_ARB_RR_EN grants M0,M1,M0,M1; without it M0,M0,M0,M0 while m1 starves.
- m1 raises req while m0 in ACCESS -> m1 granted in the IDLE after m0's RESP, never during ACCESS.
- Assert i_rst during ACCESS of a read -> no ack, strobes 0 and o_rdata 0 next cycle, subsequent m0 read completes normally.
- Master holds req one cycle past ack -> second identical access issued and acked.
